// File: rtl/clock_switch_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_switch_pkg
// Description : Shared state encoding for the clock-switch qualifier.
//               S_IDLE..S_STABLE fix the numeric values seen on the `state`
//               output. state_t is the typed view used inside the FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_switch_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_TAIL   = 2'd2;
  localparam logic [1:0] S_STABLE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_SETTLE = S_SETTLE,
    ST_TAIL   = S_TAIL,
    ST_STABLE = S_STABLE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/clock_switch_monitor_sync.sv
`default_nettype none
// ============================================================================
// Module      : clk_sample_sync
// Description : Two-flop synchronizer. It brings one asynchronous clock level
//               into the clk3 domain.
// Ports       : clk3  - sampling clock
//               reset - asynchronous, active-low
//               i_d   - raw asynchronous level
//               o_q   - synchronized level (2 clk3 cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module clk_sample_sync (
  input  logic clk3,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/clock_switch_monitor.sv
`default_nettype none
// ============================================================================
// Module      : clock_switch_monitor
// Description : Clock-switch qualifier. It samples clk_ref and the selected
//               candidate clock in the clk3 domain and flags any mismatch as
//               an event. The selected clock is declared stable only after
//               SETTLE_CYCLES + TAIL_CYCLES clean cycles.
// Ports       : clk3, reset (async, active-low)
//               start, c_lock  - arm = start & c_lock
//               mode           - 0 one-shot (sticky done), 1 continuous
//               sel            - candidate index (>= N_CLK treated as 0)
//               clk_ref        - reference clock
//               clk_in         - candidate clocks
//               state          - FSM state (IDLE/SETTLE/TAIL/STABLE)
//               clk_edge       - registered mismatch/event flag
//               counter        - settle/tail counter
//               clk_condition  - high while STABLE
//               done           - qualified-clock flag
//               lost           - one-cycle pulse on an event while STABLE
//               evt_count      - saturating count of lost pulses
// Revision    : 1.0 - initial release
// ============================================================================
module clock_switch_monitor
  import clock_switch_pkg::*;
#(
  parameter int N_CLK         = 2,
  parameter int SEL_W         = 1,
  parameter int SETTLE_CYCLES = 256,
  parameter int TAIL_CYCLES   = 6,
  parameter int CNT_W         = 11,
  parameter int EVT_W         = 8
) (
  input  logic             clk3,
  input  logic             reset,
  input  logic             start,
  input  logic             c_lock,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             clk_ref,
  input  logic [N_CLK-1:0] clk_in,
  output logic [1:0]       state,
  output logic             clk_edge,
  output logic [CNT_W-1:0] counter,
  output logic             clk_condition,
  output logic             done,
  output logic             lost,
  output logic [EVT_W-1:0] evt_count
);

  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_tail_last   = CNT_W'(TAIL_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
  localparam logic [EVT_W-1:0] c_evt_max     = '1;
  localparam logic [EVT_W-1:0] c_evt_one     = EVT_W'(1);
  // One extra bit so the range test holds even when N_CLK == 2**SEL_W.
  localparam logic [SEL_W:0]   c_n_clk       = (SEL_W + 1)'(N_CLK);

  // --------------------------------------------------------------------------
  // Sampling: bit N_CLK carries clk_ref, bits N_CLK-1:0 the candidates.
  // --------------------------------------------------------------------------
  logic [N_CLK:0] w_raw;
  logic [N_CLK:0] w_sync;

  assign w_raw = {clk_ref, clk_in};

  for (genvar gi = 0; gi <= N_CLK; gi++) begin : g_sync
    clk_sample_sync u_sync (
      .clk3  (clk3),
      .reset (reset),
      .i_d   (w_raw[gi]),
      .o_q   (w_sync[gi])
    );
  end

  logic [SEL_W-1:0] w_sel_eff;
  logic [SEL_W-1:0] r_sel;
  logic             w_cand;
  logic             w_mismatch;
  logic             r_clk_edge;

  assign w_sel_eff = ({1'b0, sel} < c_n_clk) ? sel : '0;

  // Explicit mux loop keeps the index width independent of N_CLK.
  always_comb begin
    w_cand = 1'b0;
    for (int i = 0; i < N_CLK; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_cand = w_sync[i];
      end
    end
  end

  // A select change is an event in its own right. Data from the old and new
  // candidates is never compared across the switch.
  assign w_mismatch = (w_sync[N_CLK] ^ w_cand) | (w_sel_eff != r_sel);

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      r_sel      <= '0;
      r_clk_edge <= 1'b0;
    end else begin
      r_sel      <= w_sel_eff;
      r_clk_edge <= w_mismatch;
    end
  end

  // --------------------------------------------------------------------------
  // Qualification FSM
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_counter;
  logic [CNT_W-1:0] w_counter_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_lost;
  logic             w_lost_nxt;
  logic [EVT_W-1:0] r_evt_count;
  logic [EVT_W-1:0] w_evt_nxt;
  logic             w_arm;

  assign w_arm = start & c_lock;

  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_counter   <= '0;
      r_done      <= 1'b0;
      r_lost      <= 1'b0;
      r_evt_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_counter   <= w_counter_nxt;
      r_done      <= w_done_nxt;
      r_lost      <= w_lost_nxt;
      r_evt_count <= w_evt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_counter_nxt = r_counter;
    w_done_nxt    = r_done;
    w_lost_nxt    = 1'b0;
    w_evt_nxt     = r_evt_count;

    // Disarm has priority over everything, including a coincident event;
    // evt_count is deliberately left alone here.
    if (!w_arm) begin
      w_state_nxt   = ST_IDLE;
      w_counter_nxt = '0;
      w_done_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt   = ST_SETTLE;
          w_counter_nxt = '0;
        end

        ST_SETTLE: begin
          if (r_clk_edge) begin
            w_counter_nxt = '0;
          end else if (r_counter == c_settle_last) begin
            w_state_nxt   = ST_TAIL;
            w_counter_nxt = '0;
          end else begin
            w_counter_nxt = r_counter + c_cnt_one;
          end
        end

        ST_TAIL: begin
          if (r_clk_edge) begin
            w_state_nxt   = ST_SETTLE;
            w_counter_nxt = '0;
          end else if (r_counter == c_tail_last) begin
            w_state_nxt   = ST_STABLE;
            w_counter_nxt = '0;
          end else begin
            w_counter_nxt = r_counter + c_cnt_one;
          end
        end

        ST_STABLE: begin
          w_counter_nxt = '0;
          if (r_clk_edge) begin
            w_state_nxt = ST_SETTLE;
            w_lost_nxt  = 1'b1;
            if (r_evt_count != c_evt_max) begin
              w_evt_nxt = r_evt_count + c_evt_one;
            end
            // One-shot mode keeps done sticky across events.
            if (mode) begin
              w_done_nxt = 1'b0;
            end
          end else begin
            w_done_nxt = 1'b1;
          end
        end

        default: begin
          w_state_nxt   = ST_IDLE;
          w_counter_nxt = '0;
        end
      endcase
    end
  end

  assign state         = r_state;
  assign clk_edge      = r_clk_edge;
  assign counter       = r_counter;
  assign clk_condition = (r_state == ST_STABLE);
  assign done          = r_done;
  assign lost          = r_lost;
  assign evt_count     = r_evt_count;

endmodule
`default_nettype wire

// File: tb/tb_clock_switch_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_switch_monitor
// Description : Self-checking bench for clock_switch_monitor. A behavioural
//               model describes qualification as a run length of clean
//               cycles. Each scenario task compares the DUT against that
//               model every cycle and against hand-derived timing constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_switch_monitor;

  localparam int N_CLK   = 3;
  localparam int SEL_W   = 2;
  localparam int S       = 64;
  localparam int T       = 6;
  localparam int CNT_W   = 11;
  localparam int EVT_W   = 8;
  localparam int QUAL    = S + T;
  localparam int EVT_MAX = (1 << EVT_W) - 1;
  localparam int OW      = 2 + 1 + CNT_W + 1 + 1 + 1 + EVT_W;

  logic             clk3    = 1'b0;
  logic             reset   = 1'b1;
  logic             start   = 1'b0;
  logic             c_lock  = 1'b0;
  logic             mode    = 1'b0;
  logic [SEL_W-1:0] sel     = '0;
  logic             clk_ref = 1'b0;
  logic [N_CLK-1:0] clk_in  = '0;

  logic [1:0]       state;
  logic             clk_edge;
  logic [CNT_W-1:0] counter;
  logic             clk_condition;
  logic             done;
  logic             lost;
  logic [EVT_W-1:0] evt_count;

  int checks = 0;
  int fails  = 0;
  bit noise  = 1'b0;

  always #5 clk3 = ~clk3;

  clock_switch_monitor #(
    .N_CLK(N_CLK), .SEL_W(SEL_W), .SETTLE_CYCLES(S), .TAIL_CYCLES(T),
    .CNT_W(CNT_W), .EVT_W(EVT_W)
  ) dut (
    .clk3(clk3), .reset(reset), .start(start), .c_lock(c_lock), .mode(mode),
    .sel(sel), .clk_ref(clk_ref), .clk_in(clk_in), .state(state),
    .clk_edge(clk_edge), .counter(counter), .clk_condition(clk_condition),
    .done(done), .lost(lost), .evt_count(evt_count)
  );

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic int eff_sel(input logic [SEL_W-1:0] s);
    return (int'(s) < N_CLK) ? int'(s) : 0;
  endfunction

  bit               m_armed = 0, m_done = 0, m_lost = 0, m_edge = 0;
  int               m_run = 0, m_evt = 0, s1 = 0;
  bit               p1_ref = 0, p2_ref = 0;
  logic [N_CLK-1:0] p1_in = '0, p2_in = '0;

  // m_edge: the input levels are delayed two cycles, then registered. A
  // change of the effective select is also an event.
  // m_run: clean cycles since arming or the last event, capped at QUAL.
  always @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      m_armed <= 0; m_run <= 0; m_done <= 0; m_lost <= 0; m_evt <= 0;
      m_edge <= 0; p1_ref <= 0; p2_ref <= 0; p1_in <= '0; p2_in <= '0; s1 <= 0;
    end else begin
      m_edge <= (p2_ref != p2_in[s1]) || (eff_sel(sel) != s1);
      p1_ref <= clk_ref; p2_ref <= p1_ref;
      p1_in  <= clk_in;  p2_in  <= p1_in;
      s1     <= eff_sel(sel);
      m_lost <= 1'b0;
      if (!(start && c_lock)) begin
        m_armed <= 0; m_run <= 0; m_done <= 0;
      end else if (!m_armed) begin
        m_armed <= 1; m_run <= 0;
      end else if (m_edge) begin
        m_run <= 0;
        if (m_run >= QUAL) begin
          m_lost <= 1'b1;
          if (m_evt < EVT_MAX) m_evt <= m_evt + 1;
          if (mode) m_done <= 1'b0;
        end
      end else if (m_run >= QUAL) begin
        m_done <= 1'b1;
      end else begin
        m_run <= m_run + 1;
      end
    end
  end

  logic [1:0]       e_state;
  logic [CNT_W-1:0] e_cnt;
  logic [OW-1:0]    exp_vec;
  logic [OW-1:0]    obs_vec;

  always_comb begin
    e_state = 2'd0;
    e_cnt   = '0;
    if (m_armed) begin
      if (m_run < S) begin
        e_state = 2'd1; e_cnt = CNT_W'(m_run);
      end else if (m_run < QUAL) begin
        e_state = 2'd2; e_cnt = CNT_W'(m_run - S);
      end else begin
        e_state = 2'd3;
      end
    end
  end

  assign exp_vec = {e_state, m_edge, e_cnt, (e_state == 2'd3), m_done, m_lost, EVT_W'(m_evt)};
  assign obs_vec = {state, clk_edge, counter, clk_condition, done, lost, evt_count};

  // --------------------------------------------------------------------------
  // Stimulus: one clk3 cycle. The selected candidate follows clk_ref, or its
  // inverse when glitch is set. The other candidates follow clk_ref, or are
  // random when noise is set.
  // --------------------------------------------------------------------------
  task automatic tick(input bit glitch);
    int k;
    clk_ref = 1'($urandom_range(0, 1));
    clk_in  = noise ? N_CLK'($urandom) : {N_CLK{clk_ref}};
    k = eff_sel(sel);
    clk_in[k] = clk_ref ^ glitch;
    @(posedge clk3);
    @(negedge clk3);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk3);
    reset = 1'b0;
    repeat (3) @(negedge clk3);
    checks++;
    if (obs_vec !== '0) begin
      fails++; $display("FAIL reset_values: got %h required 0", obs_vec);
    end
    reset = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick(0); checks++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL reset_idle: got %h required %h", obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_qualify();
    int rise = 0, drise = 0;
    start = 1; c_lock = 1; mode = 0; sel = '0; noise = 0;
    for (int n = 1; n <= QUAL + 4; n++) begin
      tick(0); checks++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL qualify_cycle %0d: got %h required %h", n, obs_vec, exp_vec);
      end
      if (clk_condition === 1'b1 && rise == 0) rise = n;
      if (done === 1'b1 && drise == 0) drise = n;
    end
    checks++;
    if (rise != QUAL + 1) begin
      fails++; $display("FAIL qualify_rise: got cycle %0d required %0d", rise, QUAL + 1);
    end
    checks++;
    if (drise != QUAL + 2) begin
      fails++; $display("FAIL qualify_done: got cycle %0d required %0d", drise, QUAL + 2);
    end
    checks++;
    if (evt_count !== '0) begin
      fails++; $display("FAIL qualify_evt: got %0d required 0", evt_count);
    end
  endtask

  // Re-arm from IDLE and wait for a given state/counter, then inject a
  // one-cycle mismatch. The event reaches the FSM four ticks later.
  task automatic test_glitch_in(input logic [1:0] st, input int cnt, input string name);
    bit ok = 0;
    int rise = 0;
    start = 0; tick(0);
    start = 1;
    for (int i = 0; i < QUAL + 10 && !ok; i++) begin
      tick(0); checks++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL %s_wait: got %h required %h", name, obs_vec, exp_vec);
      end
      ok = (state === st && counter === CNT_W'(cnt));
    end
    checks++;
    if (!ok) begin
      fails++; $display("FAIL %s_reach: got state %0d counter %0d required %0d/%0d", name, state, counter, st, cnt);
    end
    for (int n = 1; n <= QUAL + 8; n++) begin
      tick(n == 1); checks++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL %s_cycle %0d: got %h required %h", name, n, obs_vec, exp_vec);
      end
      if (n == 4) begin
        checks++;
        if (state !== 2'd1 || counter !== '0 || lost !== 1'b0) begin
          fails++; $display("FAIL %s_restart: got state %0d counter %0d lost %b required 1/0/0", name, state, counter, lost);
        end
      end
      if (clk_condition === 1'b1 && rise == 0) rise = n;
    end
    checks++;
    if (rise != QUAL + 4) begin
      fails++; $display("FAIL %s_rise: got cycle %0d required %0d", name, rise, QUAL + 4);
    end
  endtask

  task automatic test_stable_glitch();
    for (int m = 0; m < 2; m++) begin
      bit ok = 0, done_low = 0;
      int rise = 0, drise = 0, evt0;
      mode = 1'(m);
      for (int i = 0; i < QUAL + 20 && !ok; i++) begin
        tick(0); checks++;
        if (obs_vec !== exp_vec) begin
          fails++; $display("FAIL stable_wait: got %h required %h", obs_vec, exp_vec);
        end
        ok = (clk_condition === 1'b1 && done === 1'b1);
      end
      checks++;
      if (!ok) begin
        fails++; $display("FAIL stable_reach: got cond %b done %b required 1/1", clk_condition, done);
      end
      evt0 = m_evt;
      for (int n = 1; n <= QUAL + 8; n++) begin
        tick(n == 1); checks++;
        if (obs_vec !== exp_vec) begin
          fails++; $display("FAIL stable_m%0d_cycle %0d: got %h required %h", m, n, obs_vec, exp_vec);
        end
        if (n == 4) begin
          checks++;
          if (state !== 2'd1 || lost !== 1'b1 || clk_condition !== 1'b0 ||
              evt_count !== EVT_W'(evt0 + 1) || done !== (m == 0 ? 1'b1 : 1'b0)) begin
            fails++; $display("FAIL stable_m%0d_event: got st %0d lost %b cond %b evt %0d done %b", m, state, lost, clk_condition, evt_count, done);
          end
        end
        if (n == 5) begin
          checks++;
          if (lost !== 1'b0) begin
            fails++; $display("FAIL stable_m%0d_pulse: got lost %b required 0", m, lost);
          end
        end
        if (n > 4 && clk_condition === 1'b1 && rise == 0) rise = n;
        if (n > 4 && done === 1'b1 && drise == 0) drise = n;
        if (done !== 1'b1) done_low = 1;
      end
      checks++;
      if (rise != QUAL + 4) begin
        fails++; $display("FAIL stable_m%0d_rise: got %0d required %0d", m, rise, QUAL + 4);
      end
      checks++;
      if (m == 0 ? done_low : (drise != QUAL + 5)) begin
        fails++; $display("FAIL stable_m%0d_done: got low %b rise %0d required %s", m, done_low, drise, m == 0 ? "held" : "requal+1");
      end
    end
  endtask

  task automatic test_sel_switch();
    int evt0;
    mode = 0; noise = 0;
    evt0 = m_evt;
    sel = 2'd1;
    for (int n = 1; n <= QUAL + 6; n++) begin
      tick(0); checks++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL sel_cycle %0d: got %h required %h", n, obs_vec, exp_vec);
      end
      if (n == 1 || n == 3) begin
        checks++;
        if (clk_edge !== (n == 1 ? 1'b1 : 1'b0)) begin
          fails++; $display("FAIL sel_edge %0d: got %b required %b", n, clk_edge, n == 1);
        end
      end
      if (n == 2) begin
        checks++;
        if (lost !== 1'b1 || evt_count !== EVT_W'(evt0 + 1)) begin
          fails++; $display("FAIL sel_lost: got lost %b evt %0d required 1/%0d", lost, evt_count, evt0 + 1);
        end
      end
    end
    checks++;
    if (clk_condition !== 1'b1) begin
      fails++; $display("FAIL sel_requal: got cond %b required 1", clk_condition);
    end
    // Out-of-range select behaves as 0: 1->3 is an event, 3->0 is not.
    noise = 1;
    sel = 2'd3;
    for (int n = 1; n <= 4; n++) begin
      tick(0); checks++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL sel3_cycle %0d: got %h required %h", n, obs_vec, exp_vec);
      end
    end
    sel = 2'd0;
    for (int n = 1; n <= QUAL + 4; n++) begin
      tick(0); checks++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL sel0_cycle %0d: got %h required %h", n, obs_vec, exp_vec);
      end
    end
    checks++;
    if (clk_condition !== 1'b1 || evt_count !== EVT_W'(evt0 + 2)) begin
      fails++; $display("FAIL sel_oob: got cond %b evt %0d required 1/%0d", clk_condition, evt_count, evt0 + 2);
    end
    noise = 0;
  endtask

  task automatic test_arm_drop();
    int evt0 = m_evt;
    start = 0; c_lock = 1; tick(0);
    start = 1;
    for (int n = 0; n < 20; n++) tick(0);
    start = 0;
    tick(0); checks++;
    if (state !== 2'd0 || counter !== '0 || done !== 1'b0 || evt_count !== EVT_W'(evt0)) begin
      fails++; $display("FAIL arm_drop: got st %0d cnt %0d done %b evt %0d required 0/0/0/%0d", state, counter, done, evt_count, evt0);
    end
    // Requalify, then drop c_lock exactly when an event reaches STABLE.
    start = 1;
    for (int n = 0; n < QUAL + 3; n++) tick(0);
    checks++;
    if (clk_condition !== 1'b1 || done !== 1'b1) begin
      fails++; $display("FAIL arm_requal: got cond %b done %b required 1/1", clk_condition, done);
    end
    for (int n = 1; n <= 5; n++) begin
      if (n == 4) c_lock = 0;
      tick(n == 1); checks++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL arm_race_cycle %0d: got %h required %h", n, obs_vec, exp_vec);
      end
      if (n == 4) begin
        checks++;
        if (state !== 2'd0 || lost !== 1'b0 || done !== 1'b0 || evt_count !== EVT_W'(evt0)) begin
          fails++; $display("FAIL arm_race: got st %0d lost %b done %b evt %0d required 0/0/0/%0d", state, lost, done, evt_count, evt0);
        end
      end
    end
    c_lock = 1;
  endtask

  task automatic test_saturation();
    mode = 0; start = 1; c_lock = 1;
    for (int e = 0; e < 300; e++) begin
      bit ok = 0;
      for (int i = 0; i < QUAL + 10 && !ok; i++) begin
        tick(0); checks++;
        if (obs_vec !== exp_vec) begin
          fails++; $display("FAIL sat_cycle e%0d: got %h required %h", e, obs_vec, exp_vec);
        end
        ok = (clk_condition === 1'b1);
      end
      checks++;
      if (!ok) begin
        fails++; $display("FAIL sat_reach e%0d: got cond 0 required 1", e);
      end
      for (int n = 1; n <= 4; n++) tick(n == 1);
    end
    checks++;
    if (evt_count !== EVT_W'(EVT_MAX)) begin
      fails++; $display("FAIL sat_value: got %0d required %0d", evt_count, EVT_MAX);
    end
    reset = 0; #1; reset = 1;
    @(negedge clk3);
    checks++;
    if (evt_count !== '0) begin
      fails++; $display("FAIL sat_reset: got %0d required 0", evt_count);
    end
  endtask

  task automatic test_random();
    noise = 1; start = 1; c_lock = 1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) start = ~start;
      if (!start && $urandom_range(0, 9) == 0) start = 1;
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      if ($urandom_range(0, 399) == 0) sel = SEL_W'($urandom_range(0, 3));
      tick($urandom_range(0, 119) == 0); checks++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL random_cycle %0d: got %h required %h", n, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    #(64'd10_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_qualify();
    test_glitch_in(2'd1, 40, "settle");
    test_glitch_in(2'd2, 0, "tail");
    test_stable_glitch();
    test_sel_switch();
    test_arm_drop();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
